// File: rtl/bcd_conv_if.sv
// Start/done handshake and operand/result bus of the binary/BCD converter.
interface bcd_conv_if #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  mode;
    logic [BIN_W-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, mode, bin_in, bcd_in,
        input  busy, done, bcd_out, bin_out, err
    );

    modport slave (
        input  start, mode, bin_in, bcd_in,
        output busy, done, bcd_out, bin_out, err
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential binary<->BCD converter: one shift/adjust iteration per cycle,
// BIN_W iterations per conversion. The BCD->binary direction (with its error
// flag and bin_out register) is built only when BCD_CONV_BCD2BIN_EN is defined.
module bcd_conv_seq #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_conv_if.slave   bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic                load_c, step_c, last_c;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORK_W-1:0]   work_q, work_step_c, work_load_c;
    logic                busy_q, done_q;
    logic [BCD_W-1:0]    bcd_out_q;

`ifdef BCD_CONV_BCD2BIN_EN
    logic                mode_q, bad_q, bad_load_c, err_fin_c, err_q;
    logic [BIN_W-1:0]    bin_out_q;
`else
    logic                unused_c;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control strobes.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working-register load value and invalid-digit detection on the operand.
    always_comb begin
`ifdef BCD_CONV_BCD2BIN_EN
        work_load_c = bus.mode ? {bus.bcd_in, BIN_W'(0)} : {BCD_W'(0), bus.bin_in};
        bad_load_c  = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9) bad_load_c = 1'b1;
        end
`else
        work_load_c = {BCD_W'(0), bus.bin_in};
`endif
    end

    // One iteration: add-3 then shift left, or shift right then subtract-3.
    always_comb begin
        work_step_c = work_q;
`ifdef BCD_CONV_BCD2BIN_EN
        if (mode_q) begin
            work_step_c = work_q >> 1;
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (work_step_c[BIN_W + 4*d +: 4] >= 4'd8)
                    work_step_c[BIN_W + 4*d +: 4] = work_step_c[BIN_W + 4*d +: 4] - 4'd3;
            end
        end else
`endif
        begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (work_q[BIN_W + 4*d +: 4] >= 4'd5)
                    work_step_c[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4] + 4'd3;
            end
            work_step_c = work_step_c << 1;
        end
    end

`ifdef BCD_CONV_BCD2BIN_EN
    // Invalid input digit, or a residue left in the BCD part (value >= 2^BIN_W).
    assign err_fin_c = bad_q | (|work_step_c[WORK_W-1:BIN_W]);
`endif

    // Datapath: iteration counter, working register and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            work_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
`ifdef BCD_CONV_BCD2BIN_EN
            mode_q    <= 1'b0;
            bad_q     <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
            if (load_c) begin
                work_q <= work_load_c;
                cnt_q  <= CNT_W'(BIN_W);
`ifdef BCD_CONV_BCD2BIN_EN
                mode_q <= bus.mode;
                bad_q  <= bad_load_c;
`endif
            end else if (step_c) begin
                work_q <= work_step_c;
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            if (last_c) begin
`ifdef BCD_CONV_BCD2BIN_EN
                if (mode_q) begin
                    bin_out_q <= err_fin_c ? BIN_W'(0) : work_step_c[BIN_W-1:0];
                    err_q     <= err_fin_c;
                end else begin
                    bcd_out_q <= work_step_c[WORK_W-1:BIN_W];
                    err_q     <= 1'b0;
                end
`else
                bcd_out_q <= work_step_c[WORK_W-1:BIN_W];
`endif
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_out_q;
`ifdef BCD_CONV_BCD2BIN_EN
    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
`else
    assign bus.bin_out = '0;
    assign bus.err     = 1'b0;
    // mode and bcd_in have no function in a binary->BCD-only build.
    assign unused_c    = ^{bus.mode, bus.bcd_in};
`endif
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq with a result scoreboard checked on done.
module tb_bcd_conv_seq;
    localparam int unsigned BIN_W  = 10;
    localparam int unsigned DIGITS = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t model = '0;

    always #5 clk = ~clk;

    bcd_conv_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_conv_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int val);
        logic [15:0] r;
        int v;
        r = '0;
        v = val;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference result for one conversion, appended to the scoreboard.
    task automatic expect_conv(input logic m, input logic [9:0] b, input logic [15:0] d);
        int   v;
        logic bad;
        logic [3:0] dig;
        logic [15:0] dd;
        v   = 0;
        bad = 1'b0;
        dd  = d;
`ifdef BCD_CONV_BCD2BIN_EN
        if (m) begin
            for (int i = 3; i >= 0; i--) begin
                dig = dd[4*i +: 4];
                if (dig > 4'd9) bad = 1'b1;
                v = v * 10 + int'(dig);
            end
            if (bad || v > 1023) begin
                model.bin = '0;
                model.err = 1'b1;
            end else begin
                model.bin = 10'(v);
                model.err = 1'b0;
            end
        end else begin
            model.bcd = to_bcd(int'(b));
            model.err = 1'b0;
        end
`else
        model.bcd = to_bcd(int'(b));
        model.bin = '0;
        model.err = 1'b0;
`endif
        sb.push_back(model);
    endtask

    task automatic scramble();
        bus.bin_in = 10'($urandom);
        bus.bcd_in = 16'($urandom);
        bus.mode   = 1'($urandom);
    endtask

    // Starts one cycle after the start-accepting edge: 10 busy cycles, then done.
    task automatic run_check(input string tag);
        for (int i = 0; i < 10; i++) begin
            chk({tag, ":busy"}, 32'(bus.busy), 32'd1);
            chk({tag, ":done_early"}, 32'(bus.done), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, ":done"}, 32'(bus.done), 32'd1);
        chk({tag, ":busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic single(input string tag, input logic m, input logic [9:0] b, input logic [15:0] d);
        bus.mode   = m;
        bus.bin_in = b;
        bus.bcd_in = d;
        bus.start  = 1'b1;
        expect_conv(m, b, d);
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        run_check(tag);
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    // Scoreboard: compare results whenever done is seen.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
                chk("sb_bin_out", 32'(bus.bin_out), 32'(e.bin));
                chk("sb_err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    initial begin
        logic [15:0] rb;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.bin_in = '0;
        bus.bcd_in = '0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single("b2d_1023", 1'b0, 10'd1023, 16'h0000);

        // Back-to-back with start held: 0 then 511.
        bus.mode   = 1'b0;
        bus.bin_in = 10'd0;
        bus.start  = 1'b1;
        expect_conv(1'b0, 10'd0, 16'h0000);
        @(posedge clk); #1;
        bus.bin_in = 10'd511;
        expect_conv(1'b0, 10'd511, 16'h0000);
        run_check("b2b_0");
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        run_check("b2b_511");
        @(posedge clk); #1;
        chk("b2b_done_pulse", 32'(bus.done), 32'd0);

        single("d2b_0987", 1'b1, 10'd100, 16'h0987);
        single("d2b_1024", 1'b1, 10'd100, 16'h1024);
        single("d2b_00A5", 1'b1, 10'd100, 16'h00A5);
        single("b2d_999", 1'b0, 10'd999, 16'h0000);
        single("d2b_1023", 1'b1, 10'd1, 16'h1023);
        single("d2b_0000", 1'b1, 10'd2, 16'h0000);

        for (int n = 0; n < 6; n++) begin
            rb = '0;
            for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
            if (n == 5) rb[7:4] = 4'hF;
            single("rand", 1'(n % 2), 10'($urandom), rb);
        end

        // Reset in the middle of a conversion.
        bus.mode   = 1'b0;
        bus.bin_in = 10'd777;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        model = '0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("abort_bin_out", 32'(bus.bin_out), 32'd0);
        chk("abort_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(bus.done), 32'd0);
            chk("abort_idle", 32'(bus.busy), 32'd0);
        end

        single("post_abort_321", 1'b0, 10'd321, 16'h0000);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
